// File: rtl/sig_monitor_pkg.sv
// rtl/sig_monitor_pkg.sv - shared light codes, monitor states, fault codes and lamp patterns
package sig_monitor_pkg;

    // Light codes driven by the controller (shared with sig_control)
    localparam logic [1:0] LIGHT_RED    = 2'd0;
    localparam logic [1:0] LIGHT_YELLOW = 2'd1;
    localparam logic [1:0] LIGHT_GREEN  = 2'd2;
    localparam logic [1:0] LIGHT_BAD    = 2'd3;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_MONITOR = 2'd1,
        ST_FAULT   = 2'd2
    } state_t;

    // Fault codes, numbered by priority (lowest number wins)
    localparam logic [2:0] FC_NONE         = 3'd0;
    localparam logic [2:0] FC_CONFLICT     = 3'd1;
    localparam logic [2:0] FC_INVALID      = 3'd2;
    localparam logic [2:0] FC_TRANSITION   = 3'd3;
    localparam logic [2:0] FC_SHORT_YELLOW = 3'd4;
    localparam logic [2:0] FC_SHORT_ALLRED = 3'd5;

    // One-hot lamp drive {R,Y,G}
    localparam logic [2:0] LAMP_R   = 3'b100;
    localparam logic [2:0] LAMP_Y   = 3'b010;
    localparam logic [2:0] LAMP_G   = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    // Legal per-road steps: hold, G->Y, Y->R, R->G
    function automatic logic legal_step(input logic [1:0] prev, input logic [1:0] cur);
        return (prev == cur)
            || (prev == LIGHT_GREEN  && cur == LIGHT_YELLOW)
            || (prev == LIGHT_YELLOW && cur == LIGHT_RED)
            || (prev == LIGHT_RED    && cur == LIGHT_GREEN);
    endfunction

endpackage

// File: rtl/sig_monitor_lamp_decode.sv
// rtl/sig_monitor_lamp_decode.sv - 2-bit light code to one-hot {R,Y,G} lamp drive
//   code : light code (RED/YELLOW/GREEN, 3 invalid)
//   lamp : one-hot lamp drive, 3'b000 for the invalid code
module lamp_decode
    import sig_monitor_pkg::*;
(
    input  logic [1:0] code,
    output logic [2:0] lamp
);

    always_comb begin
        lamp = LAMP_OFF;
        case (code)
            LIGHT_RED:    lamp = LAMP_R;
            LIGHT_YELLOW: lamp = LAMP_Y;
            LIGHT_GREEN:  lamp = LAMP_G;
            default:      lamp = LAMP_OFF;
        endcase
    end

endmodule

// File: rtl/sig_monitor.sv
// rtl/sig_monitor.sv - traffic-light safety monitor with latched fault and red flash
//   clock      : single clock, rising edge
//   clear_n    : synchronous active-low reset
//   HIGHWAY    : highway light code from controller
//   COUNTRY    : country light code from controller
//   HW_LAMP    : highway lamp drive {R,Y,G}
//   CT_LAMP    : country lamp drive {R,Y,G}
//   FAULT      : latched fault flag
//   FAULT_CODE : first fault detected, 0 = none
module sig_monitor
    import sig_monitor_pkg::*;
#(
    parameter int YMIN       = 3,
    parameter int ALLRED_MIN = 2,
    parameter int FLASH_HALF = 4
) (
    input  logic       clock,
    input  logic       clear_n,
    input  logic [1:0] HIGHWAY,
    input  logic [1:0] COUNTRY,
    output logic [2:0] HW_LAMP,
    output logic [2:0] CT_LAMP,
    output logic       FAULT,
    output logic [2:0] FAULT_CODE
);

    localparam int YW = $clog2(YMIN + 1);
    localparam int AW = $clog2(ALLRED_MIN + 1);
    localparam int FW = $clog2(2 * FLASH_HALF);

    localparam logic [YW-1:0] YSAT  = YW'(YMIN);
    localparam logic [AW-1:0] ASAT  = AW'(ALLRED_MIN);
    localparam logic [FW-1:0] FHALF = FW'(FLASH_HALF);
    localparam logic [FW-1:0] FLAST = FW'(2 * FLASH_HALF - 1);

    state_t        state_q, state_d;
    logic [1:0]    hw_cur, ct_cur, hw_prev, ct_prev;
    logic [YW-1:0] hw_ycnt, ct_ycnt;
    logic [AW-1:0] ar_cnt;
    logic [FW-1:0] fcnt_q, fcnt_d, fcnt_nxt;
    logic [2:0]    hw_lamp_d, ct_lamp_d, code_d;
    logic [2:0]    hw_dec, ct_dec;
    logic [2:0]    fault_now;
    logic          conflict, invalid, bad_step, short_y, short_ar;

    lamp_decode u_hw_decode (.code(hw_cur), .lamp(hw_dec));
    lamp_decode u_ct_decode (.code(ct_cur), .lamp(ct_dec));

    // Counters are advanced from cur, so during a cycle they hold the run
    // length ending at prev -- exactly what the Y->R and R->G checks need.
    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state_q    <= ST_HOLD;
            hw_cur     <= LIGHT_RED;
            ct_cur     <= LIGHT_RED;
            hw_prev    <= LIGHT_RED;
            ct_prev    <= LIGHT_RED;
            hw_ycnt    <= '0;
            ct_ycnt    <= '0;
            ar_cnt     <= '0;
            fcnt_q     <= '0;
            HW_LAMP    <= LAMP_R;
            CT_LAMP    <= LAMP_R;
            FAULT_CODE <= FC_NONE;
        end else begin
            state_q    <= state_d;
            hw_prev    <= hw_cur;
            ct_prev    <= ct_cur;
            hw_cur     <= HIGHWAY;
            ct_cur     <= COUNTRY;
            hw_ycnt    <= (hw_cur != LIGHT_YELLOW) ? '0 :
                          (hw_ycnt == YSAT) ? YSAT : hw_ycnt + 1'b1;
            ct_ycnt    <= (ct_cur != LIGHT_YELLOW) ? '0 :
                          (ct_ycnt == YSAT) ? YSAT : ct_ycnt + 1'b1;
            ar_cnt     <= (hw_cur != LIGHT_RED || ct_cur != LIGHT_RED) ? '0 :
                          (ar_cnt == ASAT) ? ASAT : ar_cnt + 1'b1;
            fcnt_q     <= fcnt_d;
            HW_LAMP    <= hw_lamp_d;
            CT_LAMP    <= ct_lamp_d;
            FAULT_CODE <= code_d;
        end
    end

    assign FAULT = (state_q == ST_FAULT);

    // Safety checks on the current sample pair
    always_comb begin
        conflict = (hw_cur != LIGHT_RED) && (ct_cur != LIGHT_RED);
        invalid  = (hw_cur == LIGHT_BAD) || (ct_cur == LIGHT_BAD);
        bad_step = !legal_step(hw_prev, hw_cur) || !legal_step(ct_prev, ct_cur);
        short_y  = (hw_prev == LIGHT_YELLOW && hw_cur == LIGHT_RED && hw_ycnt < YSAT)
                || (ct_prev == LIGHT_YELLOW && ct_cur == LIGHT_RED && ct_ycnt < YSAT);
        short_ar = ((hw_prev == LIGHT_RED && hw_cur == LIGHT_GREEN)
                 || (ct_prev == LIGHT_RED && ct_cur == LIGHT_GREEN)) && (ar_cnt < ASAT);

        fault_now = FC_NONE;
        if (conflict)
            fault_now = FC_CONFLICT;
        else if (invalid)
            fault_now = FC_INVALID;
        else if (state_q == ST_MONITOR) begin
            // prev is only meaningful once HOLD has passed
            if (bad_step)
                fault_now = FC_TRANSITION;
            else if (short_y)
                fault_now = FC_SHORT_YELLOW;
            else if (short_ar)
                fault_now = FC_SHORT_ALLRED;
        end
    end

    // Next state, fault capture and lamp register inputs
    always_comb begin
        state_d   = state_q;
        code_d    = FAULT_CODE;
        fcnt_d    = fcnt_q;
        fcnt_nxt  = (fcnt_q == FLAST) ? '0 : fcnt_q + 1'b1;
        hw_lamp_d = hw_dec;
        ct_lamp_d = ct_dec;

        case (state_q)
            ST_HOLD:    state_d = (fault_now != FC_NONE) ? ST_FAULT : ST_MONITOR;
            ST_MONITOR: if (fault_now != FC_NONE) state_d = ST_FAULT;
            ST_FAULT:   state_d = ST_FAULT;
            default:    state_d = ST_HOLD;
        endcase

        if (state_d == ST_FAULT) begin
            if (state_q != ST_FAULT) begin
                // Entry edge: the offending sample is replaced by the first red phase
                code_d    = fault_now;
                fcnt_d    = '0;
                hw_lamp_d = LAMP_R;
                ct_lamp_d = LAMP_R;
            end else begin
                fcnt_d    = fcnt_nxt;
                hw_lamp_d = (fcnt_nxt < FHALF) ? LAMP_R : LAMP_OFF;
                ct_lamp_d = (fcnt_nxt < FHALF) ? LAMP_R : LAMP_OFF;
            end
        end else if (state_q == ST_HOLD) begin
            hw_lamp_d = LAMP_R;
            ct_lamp_d = LAMP_R;
        end
    end

endmodule

// File: tb/tb_sig_monitor.sv
// tb/tb_sig_monitor.sv - scoreboard bench for sig_monitor
module tb_sig_monitor;

    localparam logic [1:0] R = 2'd0, Y = 2'd1, G = 2'd2, X = 2'd3;

    logic       clock = 1'b0;
    logic       clear_n;
    logic [1:0] HIGHWAY, COUNTRY;
    logic [2:0] HW_LAMP, CT_LAMP;
    logic       FAULT;
    logic [2:0] FAULT_CODE;

    always #5 clock = ~clock;

    sig_monitor #(.YMIN(3), .ALLRED_MIN(2), .FLASH_HALF(4)) dut (
        .clock      (clock),
        .clear_n    (clear_n),
        .HIGHWAY    (HIGHWAY),
        .COUNTRY    (COUNTRY),
        .HW_LAMP    (HW_LAMP),
        .CT_LAMP    (CT_LAMP),
        .FAULT      (FAULT),
        .FAULT_CODE (FAULT_CODE)
    );

    typedef struct {
        int         due;
        logic [2:0] hw;
        logic [2:0] ct;
        logic       f;
        logic [2:0] code;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_bad  = 0;
    logic mis;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [2:0] lamp_of(input logic [1:0] c);
        case (c)
            R:       return 3'b100;
            Y:       return 3'b010;
            G:       return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            n_vec++;
            mis = 1'b0;
            if (e.due != cyc) begin
                mis = 1'b1;
                $display("FAIL %s: got check at cyc=%0d, want cyc=%0d", e.name, cyc, e.due);
            end
            if (HW_LAMP !== e.hw) begin
                mis = 1'b1;
                $display("FAIL %s cyc=%0d: got hw=%b, want hw=%b", e.name, cyc, HW_LAMP, e.hw);
            end
            if (CT_LAMP !== e.ct) begin
                mis = 1'b1;
                $display("FAIL %s cyc=%0d: got ct=%b, want ct=%b", e.name, cyc, CT_LAMP, e.ct);
            end
            if (FAULT !== e.f) begin
                mis = 1'b1;
                $display("FAIL %s cyc=%0d: got fault=%b, want fault=%b", e.name, cyc, FAULT, e.f);
            end
            if (FAULT_CODE !== e.code) begin
                mis = 1'b1;
                $display("FAIL %s cyc=%0d: got code=%0d, want code=%0d", e.name, cyc, FAULT_CODE, e.code);
            end
            if (mis)
                n_bad++;
        end
    end

    task automatic push(input int due, input logic [2:0] hw, input logic [2:0] ct,
                        input logic f, input logic [2:0] code, input string name);
        exp_t x;
        x.due = due; x.hw = hw; x.ct = ct; x.f = f; x.code = code; x.name = name;
        sb.push_back(x);
    endtask

    task automatic drive(input logic [1:0] hw, input logic [1:0] ct, input string name);
        push(cyc + 2, lamp_of(hw), lamp_of(ct), 1'b0, 3'd0, name);
        HIGHWAY = hw;
        COUNTRY = ct;
        @(posedge clock); #1;
    endtask

    task automatic drive_fault(input logic [1:0] hw, input logic [1:0] ct,
                               input logic [2:0] code, input string name);
        push(cyc + 2, 3'b100, 3'b100, 1'b1, code, name);
        HIGHWAY = hw;
        COUNTRY = ct;
        @(posedge clock); #1;
    endtask

    task automatic fault_tail(input logic [2:0] code, input int n, input string name);
        for (int k = 1; k <= n; k++) begin
            logic [2:0] l;
            l = ((k % 8) < 4) ? 3'b100 : 3'b000;
            push(cyc + 2, l, l, 1'b1, code, name);
            HIGHWAY = (k == 2) ? X : R;
            COUNTRY = R;
            @(posedge clock); #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        clear_n = 1'b0;
        HIGHWAY = R;
        COUNTRY = R;
        push(cyc + 1, 3'b100, 3'b100, 1'b0, 3'd0, "reset");
        @(posedge clock); #1;
        clear_n = 1'b1;
        push(cyc + 1, 3'b100, 3'b100, 1'b0, 3'd0, "hold");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout, want summary");
        $fatal(1);
    end

    initial begin
        clear_n = 1'b0;
        HIGHWAY = R;
        COUNTRY = R;

        do_reset();
        repeat (3) drive(R, R, "idle_red");
        repeat (5) drive(G, R, "hw_green");
        repeat (4) drive(Y, R, "hw_yellow");
        repeat (3) drive(R, R, "all_red");
        repeat (3) drive(R, G, "ct_green");
        repeat (3) drive(R, Y, "ct_yellow");
        repeat (2) drive(R, R, "all_red2");
        repeat (2) drive(G, R, "hw_green2");

        drive_fault(G, G, 3'd1, "conflict");
        fault_tail(3'd1, 9, "flash_conflict");

        do_reset();
        repeat (3) drive(R, R, "post_reset_red");
        repeat (2) drive(G, R, "post_reset_green");
        repeat (2) drive(Y, R, "short_y_yellow");
        drive_fault(R, R, 3'd4, "short_yellow");
        fault_tail(3'd4, 3, "flash_short_yellow");

        do_reset();
        repeat (3) drive(R, R, "ok_red");
        repeat (2) drive(G, R, "ok_green");
        repeat (3) drive(Y, R, "ok_yellow3");
        repeat (2) drive(R, R, "ok_allred2");
        repeat (2) drive(R, G, "ok_ct_green");

        do_reset();
        repeat (3) drive(R, R, "ill_red");
        repeat (2) drive(G, R, "ill_green");
        drive_fault(R, R, 3'd3, "illegal_g_to_r");
        fault_tail(3'd3, 2, "flash_illegal");

        do_reset();
        repeat (3) drive(R, R, "pri_red");
        repeat (2) drive(G, R, "pri_green");
        drive_fault(R, X, 3'd2, "priority_invalid");
        fault_tail(3'd2, 2, "flash_priority");

        do_reset();
        repeat (3) drive(R, R, "sar_red");
        repeat (2) drive(G, R, "sar_green");
        repeat (3) drive(Y, R, "sar_yellow");
        drive(R, R, "sar_allred1");
        drive_fault(R, G, 3'd5, "short_allred");
        fault_tail(3'd5, 2, "flash_short_allred");

        repeat (4) @(posedge clock);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL %s: got no check by cyc=%0d, want check at cyc=%0d", e.name, cyc, e.due);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        if (n_bad != 0)
            $display("FAIL summary: got %0d miscompares, want 0", n_bad);
        else
            $display("PASS");
        $finish;
    end

endmodule
